ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 fetch_req  in  1  one-cycle pulse from ctrl requesting the next instruction.
REQ-004 br_take  in  1  one-cycle pulse from ctrl to load PC from branch logic.
REQ-005 br_rel  in  1  1 = PC-relative target, 0 = absolute target; sampled with br_take.
REQ-006 br_addr  in  16  branch target or signed offset.
REQ-007 mem_rd  out  1  instruction-memory read request; held until mem_ack.
REQ-008 mem_addr  out  16  read address; equals the PC while mem_rd = 1.
REQ-009 mem_ack  in  1  memory response strobe; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  in  32  instruction word.
REQ-011 ir  out  32  instruction register.
REQ-012 opcode  out  4  ir[31:28], registered, consumed by ctrl.
REQ-013 mm  out  4  ir[27:24], registered addressing mode, consumed by ctrl.
REQ-014 ir_valid  out  1  high from instruction capture until the next accepted fetch_req.
REQ-015 pc  out  16  current program counter.
REQ-016 busy  out  1  high in every state except IDLE and HALT.
REQ-017 halted  out  1  high in HALT.

Function
REQ-018 The FSM shall have four states: IDLE, WAIT, CAPT and HALT.
REQ-019 In IDLE, a fetch_req shall move to WAIT; mem_rd = 1 and mem_addr = pc shall be driven from the next cycle.
REQ-020 In WAIT, mem_rd shall hold at 1 with a stable mem_addr until mem_ack = 1; mem_rdata shall then be captured into ir and the FSM shall move to CAPT.
REQ-021 In CAPT (one cycle), ir_valid = 1, pc <= pc + 1 (mod 2^16), and the next state shall be IDLE, or HALT if opcode = 15.
REQ-022 Minimum fetch latency: fetch_req in cycle N, mem_ack in cycle N+1, ir_valid high in cycle N+2.
REQ-023 A fetch_req while busy or halted shall be ignored and not queued.
REQ-024 A br_take in IDLE shall set pc <= br_rel ? pc + br_addr : br_addr, with 16-bit wrap and the offset taken as two's complement.
REQ-025 A br_take while busy shall be latched once and applied in the cycle after CAPT, overriding that cycle's increment result.
REQ-026 A second br_take while one is already pending shall replace the pending target.
REQ-027 If br_take and fetch_req arrive together in IDLE, the branch shall update pc and the fetch_req shall be ignored.
REQ-028 A mem_ack outside WAIT shall be ignored.
REQ-029 HALT shall be left only by rst.

Reset
REQ-030 On rst = 1 at a rising edge: state = IDLE, pc = 0, ir = 0, opcode = 0, mm = 0, ir_valid = 0, mem_rd = 0, mem_addr = 0, halted = 0, and any pending branch is cleared.
REQ-031 rst during WAIT shall drop mem_rd in the next cycle; a late mem_ack shall be ignored.

Configuration
REQ-032 With IFETCH_TIMEOUT_EN defined, a 5-bit counter shall run in WAIT.
REQ-033 If the counter reaches 31 cycles without mem_ack, then: mem_rd is dropped; output fetch_err (1 bit) pulses for one cycle; the FSM returns to IDLE; pc is unchanged; ir is unchanged.
REQ-034 Without IFETCH_TIMEOUT_EN, WAIT shall wait indefinitely, and the fetch_err port and counter shall be absent.

Structure
REQ-035 Package sisc_pkg shall hold the state encoding, the opcode constants (NOOP=0 .. ALU_OP=8, HLT=15), the field positions (OPC_MSB=31, MM_MSB=27) and TIMEOUT_MAX=31.
REQ-036 Sub-module ifetch_pc shall contain the PC register, the increment and branch adder, and the pending-branch latch; the FSM shall stay in ifetch.

Verification
REQ-037 Reset, then fetch_req with mem_ack one cycle later and mem_rdata=32'h1A00_0005 -> in cycle N+2: ir_valid=1, opcode=1, mm=4'hA, pc=1.
REQ-038 fetch_req with mem_ack delayed 7 cycles -> mem_rd and mem_addr=0 stable for 7 cycles; a second fetch_req during the wait is ignored.
REQ-039 pc=16'hFFFE, br_take with br_rel=1 and br_addr=16'h0003 -> pc=16'h0001; br_take during WAIT with absolute target 16'h0040 -> pc=16'h0040 after CAPT.
REQ-040 Fetch of mem_rdata=32'hF000_0000 -> halted=1; later fetch_req ignored; rst clears halted to 0.
REQ-041 IFETCH_TIMEOUT_EN defined, no mem_ack -> fetch_err pulses after 31 cycles, mem_rd=0, pc unchanged; rst asserted mid-WAIT -> mem_rd=0 next cycle.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state encoding,
// opcode values, instruction field positions and the fetch timeout limit.
package sisc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  typedef enum logic [3:0] {
    NOOP   = 4'd0,
    LDA    = 4'd1,
    STA    = 4'd2,
    LDI    = 4'd3,
    JMP    = 4'd4,
    JZ     = 4'd5,
    CALL   = 4'd6,
    RET    = 4'd7,
    ALU_OP = 4'd8,
    HLT    = 4'd15
  } opcode_e;

  localparam int OPC_MSB     = 31;
  localparam int MM_MSB      = 27;
  localparam int TIMEOUT_MAX = 31;

  // Branch target: relative offsets are two's complement and wrap at 16 bits.
  function automatic logic [15:0] br_target(input logic [15:0] cur_pc,
                                            input logic        rel,
                                            input logic [15:0] addr);
    return rel ? (cur_pc + addr) : addr;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read bus between ifetch (master) and memory (slave).
interface ifetch_if;

  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/ifetch_pc.sv
// Program counter with increment/branch adder and a single pending-branch
// slot for branches that arrive while a fetch is in flight.
module ifetch_pc
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        br_take,
  input  logic        br_rel,
  input  logic [15:0] br_addr,
  input  logic        pc_inc,
  input  logic        br_now,
  input  logic        br_hold,
  input  logic        br_apply,
  output logic [15:0] pc
);

  logic        pend_vld;
  logic        pend_rel;
  logic [15:0] pend_addr;

  // A relative pending branch is resolved against the already-incremented pc
  // at the moment it is applied; a br_take in the apply cycle itself wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      pend_vld  <= 1'b0;
      pend_rel  <= 1'b0;
      pend_addr <= '0;
    end else begin
      if (br_apply) begin
        if (br_take)       pc <= br_target(pc, br_rel, br_addr);
        else if (pend_vld) pc <= br_target(pc, pend_rel, pend_addr);
        pend_vld <= 1'b0;
      end else if (br_now && br_take) begin
        pc <= br_target(pc, br_rel, br_addr);
      end else if (pc_inc) begin
        pc <= pc + 16'd1;
      end
      if (br_hold && br_take) begin
        pend_vld  <= 1'b1;
        pend_rel  <= br_rel;
        pend_addr <= br_addr;
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch controller: issues one memory read per fetch_req,
// captures the word into ir and advances the pc.
// Optional build macro IFETCH_TIMEOUT_EN adds a WAIT timeout and fetch_err.
//
// state | meaning
// IDLE  | ready; accepts fetch_req or an immediate branch
// WAIT  | mem_rd asserted at pc, waiting for mem_ack
// CAPT  | one cycle with the new instruction; pending branch applied
// HALT  | HLT fetched; only rst leaves
module ifetch
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        br_take,
  input  logic        br_rel,
  input  logic [15:0] br_addr,
  ifetch_if.master    mem,
  output logic [31:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic        ir_valid,
  output logic [15:0] pc,
  output logic        busy,
`ifdef IFETCH_TIMEOUT_EN
  output logic        fetch_err,
`endif
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic         accept;
  logic         capture;
  logic         timeout;

  assign accept  = (state_q == IDLE) && fetch_req && !br_take;
  assign capture = (state_q == WAIT) && mem.mem_ack;

`ifdef IFETCH_TIMEOUT_EN
  logic [4:0] tmo_cnt;

  assign timeout = (state_q == WAIT) && !mem.mem_ack && (tmo_cnt == 5'd0);

  // Down-counter reloaded outside WAIT; reaching zero marks the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= timeout;
      if (state_q != WAIT) tmo_cnt <= 5'(TIMEOUT_MAX - 1);
      else                 tmo_cnt <= tmo_cnt - 5'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (mem.mem_ack)  state_d = CAPT;
        else if (timeout) state_d = IDLE;
      end
      CAPT: state_d = (opcode == HLT) ? HALT : IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Instruction register and decoded fields, loaded on the acknowledged read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      opcode   <= '0;
      mm       <= '0;
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir       <= mem.mem_rdata;
      opcode   <= mem.mem_rdata[OPC_MSB -: 4];
      mm       <= mem.mem_rdata[MM_MSB -: 4];
      ir_valid <= 1'b1;
    end else if (accept) begin
      ir_valid <= 1'b0;
    end
  end

  assign mem.mem_rd   = (state_q == WAIT);
  assign mem.mem_addr = (state_q == WAIT) ? pc : 16'd0;
  assign busy         = (state_q == WAIT) || (state_q == CAPT);
  assign halted       = (state_q == HALT);

  ifetch_pc u_pc (
    .clk      (clk),
    .rst      (rst),
    .br_take  (br_take),
    .br_rel   (br_rel),
    .br_addr  (br_addr),
    .pc_inc   (capture),
    .br_now   (state_q == IDLE),
    .br_hold  (state_q == WAIT),
    .br_apply (state_q == CAPT),
    .pc       (pc)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch; timeout checks compile in with IFETCH_TIMEOUT_EN.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        br_take;
  logic        br_rel;
  logic [15:0] br_addr;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic        ir_valid;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
`ifdef IFETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int n_total = 0;
  int n_pass  = 0;

  ifetch_if mem_bus ();

  ifetch dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .br_take   (br_take),
    .br_rel    (br_rel),
    .br_addr   (br_addr),
    .mem       (mem_bus),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .busy      (busy),
`ifdef IFETCH_TIMEOUT_EN
    .fetch_err (fetch_err),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_req = 1'b0; br_take = 1'b0; br_rel = 1'b0; br_addr = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_opc_mm", {24'h0, opcode, mm}, 32'h0);
    chk("rst_irv", 32'(ir_valid), 32'h0);
    chk("rst_memrd", 32'(mem_bus.mem_rd), 32'h0);
    chk("rst_memaddr", 32'(mem_bus.mem_addr), 32'h0);
    chk("rst_busy_halt", {30'h0, busy, halted}, 32'h0);
    rst = 1'b0;

    // minimum-latency fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("f1_memrd", 32'(mem_bus.mem_rd), 32'h1);
    chk("f1_memaddr", 32'(mem_bus.mem_addr), 32'h0);
    chk("f1_busy", 32'(busy), 32'h1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1A00_0005;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("f1_irv", 32'(ir_valid), 32'h1);
    chk("f1_opcode", 32'(opcode), 32'h1);
    chk("f1_mm", 32'(mm), 32'hA);
    chk("f1_pc", 32'(pc), 32'h1);
    chk("f1_ir", ir, 32'h1A00_0005);
    tick();
    chk("f1_idle_busy", 32'(busy), 32'h0);
    chk("f1_idle_irv", 32'(ir_valid), 32'h1);
    chk("f1_idle_pc", 32'(pc), 32'h1);

    // slow memory, extra fetch_req during WAIT ignored
    do_reset();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("f2_memrd", 32'(mem_bus.mem_rd), 32'h1);
      chk("f2_memaddr", 32'(mem_bus.mem_addr), 32'h0);
      fetch_req = (i == 2);
      tick();
    end
    fetch_req = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h2300_0000;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("f2_opcode", 32'(opcode), 32'h2);
    chk("f2_mm", 32'(mm), 32'h3);
    chk("f2_pc", 32'(pc), 32'h1);
    tick();
    chk("f2_idle", 32'(busy), 32'h0);
    tick();
    chk("f2_noqueue", 32'(mem_bus.mem_rd), 32'h0);

    // stray mem_ack in IDLE
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("stray_ack_ir", ir, 32'h2300_0000);
    chk("stray_ack_busy", 32'(busy), 32'h0);

    // branches in IDLE
    br_take = 1'b1; br_rel = 1'b0; br_addr = 16'hFFFE;
    tick();
    chk("br_abs", 32'(pc), 32'hFFFE);
    br_rel = 1'b1; br_addr = 16'h0003;
    tick();
    chk("br_rel_wrap", 32'(pc), 32'h0001);
    br_rel = 1'b0; br_addr = 16'h0010; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("br_fetch_pc", 32'(pc), 32'h0010);
    chk("br_fetch_memrd", 32'(mem_bus.mem_rd), 32'h0);
    br_rel = 1'b1; br_addr = 16'hFFFF;
    tick();
    br_take = 1'b0;
    chk("br_rel_neg", 32'(pc), 32'h000F);

    // branches during WAIT: second replaces first, applied after CAPT
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("pend_irv_clr", 32'(ir_valid), 32'h0);
    br_take = 1'b1; br_rel = 1'b0; br_addr = 16'h0033;
    tick();
    br_addr = 16'h0040;
    chk("pend_addr_stable", 32'(mem_bus.mem_addr), 32'h000F);
    chk("pend_pc_hold", 32'(pc), 32'h000F);
    tick();
    br_take = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h8000_0000;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("pend_capt_pc", 32'(pc), 32'h0010);
    chk("pend_capt_opc", 32'(opcode), 32'h8);
    tick();
    chk("pend_applied", 32'(pc), 32'h0040);
    tick();
    chk("pend_once", 32'(pc), 32'h0040);

    // HLT
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hF000_0000;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("hlt_opcode", 32'(opcode), 32'hF);
    tick();
    chk("hlt_halted", 32'(halted), 32'h1);
    chk("hlt_busy", 32'(busy), 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("hlt_ignore_fetch", 32'(mem_bus.mem_rd), 32'h0);
    chk("hlt_stays", 32'(halted), 32'h1);
    do_reset();
    chk("hlt_rst_halted", 32'(halted), 32'h0);
    chk("hlt_rst_pc", 32'(pc), 32'h0);
    chk("hlt_rst_ir", ir, 32'h0);

    // rst mid-WAIT, late ack ignored
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("rstw_memrd_on", 32'(mem_bus.mem_rd), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_memrd_off", 32'(mem_bus.mem_rd), 32'h0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("rstw_late_ir", ir, 32'h0);
    chk("rstw_late_irv", 32'(ir_valid), 32'h0);
    chk("rstw_late_busy", 32'(busy), 32'h0);

`ifdef IFETCH_TIMEOUT_EN
    br_take = 1'b1; br_rel = 1'b0; br_addr = 16'h0005;
    tick();
    br_take = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      chk("tmo_wait_err", 32'(fetch_err), 32'h0);
      chk("tmo_wait_rd", 32'(mem_bus.mem_rd), 32'h1);
      tick();
    end
    chk("tmo_last_rd", 32'(mem_bus.mem_rd), 32'h1);
    chk("tmo_last_err", 32'(fetch_err), 32'h0);
    tick();
    chk("tmo_err", 32'(fetch_err), 32'h1);
    chk("tmo_memrd", 32'(mem_bus.mem_rd), 32'h0);
    chk("tmo_pc", 32'(pc), 32'h0005);
    chk("tmo_ir", ir, 32'h0);
    chk("tmo_busy", 32'(busy), 32'h0);
    tick();
    chk("tmo_err_pulse", 32'(fetch_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
